multi_mode_ff_bank: RTL and testbench

//   WIDTH-bit bank of universal flip-flops. Every bit is updated on the same

---
 rtl/multi_mode_ff_bank_if.sv | 18 +
 rtl/multi_mode_ff_bank.sv | 50 +++++
 tb/tb_multi_mode_ff_bank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/multi_mode_ff_bank_if.sv
// multi_mode_ff_bank_if: control/data bundle for the universal flip-flop bank
interface multi_mode_ff_bank_if #(
  parameter int WIDTH = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 en;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 clr_err;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qb;
  logic                 err;
  logic [WIDTH-1:0]     err_vec;
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (output en, mode, a, b, clr_err, input q, qb, err, err_vec, err_cnt);
  modport slave (input en, mode, a, b, clr_err, output q, qb, err, err_vec, err_cnt);
endinterface

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-bit SR/JK/D/T flip-flop bank with forbidden-SR flagging.
// Macro UFF_ERR_CNT_EN adds a saturating error-cycle counter on err_cnt (tied to 0 otherwise).
module multi_mode_ff_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  multi_mode_ff_bank_if.slave bus
);
  logic [WIDTH-1:0] q_r, qb_r, vec_r, q_next, vec_next, sr_next, jk_next;
  logic err_r, bad;
  // SR 11 falls through both terms and holds q
  assign sr_next = (q_r | (bus.a & ~bus.b)) & ~(~bus.a & bus.b);
  assign jk_next = (q_r & ~bus.b) | (~q_r & bus.a);
  assign q_next = bus.mode == 2'b00 ? sr_next :
                  bus.mode == 2'b01 ? jk_next :
                  bus.mode == 2'b10 ? bus.a : q_r ^ bus.a;
  assign vec_next = bus.mode == 2'b00 ? bus.a & bus.b : '0;
  assign bad = bus.en && |vec_next;
  always_ff @(posedge clk)
    if (rst) begin
      q_r <= RESET_VAL;
      qb_r <= ~RESET_VAL;
      vec_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (bus.en) begin
        q_r <= q_next;
        qb_r <= ~q_next;
        vec_r <= vec_next;
      end
      err_r <= bad ? 1'b1 : bus.clr_err ? 1'b0 : err_r;
    end
  assign bus.q = q_r;
  assign bus.qb = qb_r;
  assign bus.err = err_r;
  assign bus.err_vec = vec_r;
`ifdef UFF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_r;
  always_ff @(posedge clk)
    if (rst) cnt_r <= '0;
    else if (bad) cnt_r <= bus.clr_err ? ERR_CNT_W'(1) : &cnt_r ? cnt_r : cnt_r + ERR_CNT_W'(1);
    else if (bus.clr_err) cnt_r <= '0;
  assign bus.err_cnt = cnt_r;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb_multi_mode_ff_bank: directed and random checks of the flip-flop bank against a per-bit behavioural model
module tb_multi_mode_ff_bank;
  localparam int W = 4;
  localparam int CW = 2;
`ifdef UFF_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] mq = '0, mvec = '0;
  logic merr = 1'b0;
  int mcnt = 0;

  multi_mode_ff_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus ();
  multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL('0), .ERR_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int cnt_exp(input int n);
    return CNT_ON ? n : 0;
  endfunction

  // Reference: each bit evaluated independently from its characteristic table
  task automatic model(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
    logic [W-1:0] nq, fv;
    int maxc;
    maxc = (1 << CW) - 1;
    if (r) begin
      mq = '0; mvec = '0; merr = 1'b0; mcnt = 0;
      return;
    end
    if (!e) begin
      if (c) begin merr = 1'b0; mcnt = 0; end
      return;
    end
    for (int i = 0; i < W; i++) begin
      nq[i] = mq[i];
      fv[i] = 1'b0;
      case (m)
        2'd0: if (aa[i] && bb[i]) fv[i] = 1'b1; else if (aa[i]) nq[i] = 1'b1; else if (bb[i]) nq[i] = 1'b0;
        2'd1: if (aa[i] && bb[i]) nq[i] = !mq[i]; else if (aa[i]) nq[i] = 1'b1; else if (bb[i]) nq[i] = 1'b0;
        2'd2: nq[i] = aa[i];
        default: if (aa[i]) nq[i] = !mq[i];
      endcase
    end
    mq = nq;
    mvec = fv;
    if (fv != 0) begin
      merr = 1'b1;
      mcnt = CNT_ON ? (c ? 1 : (mcnt < maxc ? mcnt + 1 : maxc)) : 0;
    end else if (c) begin
      merr = 1'b0; mcnt = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
    rst = r; bus.en = e; bus.mode = m; bus.a = aa; bus.b = bb; bus.clr_err = c;
    model(r, e, m, aa, bb, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1, 1, 2'b10, 4'hF, 4'h0, 0);
    step(1, 1, 2'b10, 4'hF, 4'h0, 0);
    total++; if (bus.q !== 4'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", bus.q); end
    total++; if (bus.qb !== 4'hF) begin bad++; $display("FAIL reset_qb got=%h exp=f", bus.qb); end
    total++; if (bus.err !== 1'b0 || bus.err_vec !== 4'h0) begin bad++; $display("FAIL reset_err got=%b/%h exp=0/0", bus.err, bus.err_vec); end
    total++; if (bus.err_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.err_cnt); end
  endtask

  task automatic test_sr;
    logic [W-1:0] av[3] = '{4'b1010, 4'b0000, 4'b0000};
    logic [W-1:0] bv[3] = '{4'b0000, 4'b0010, 4'b0000};
    logic [W-1:0] ev[3] = '{4'b1010, 4'b1000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b00, av[i], bv[i], 0);
      total++; if (bus.q !== ev[i] || bus.qb !== ~ev[i]) begin bad++; $display("FAIL sr_%0d got q=%b qb=%b exp q=%b", i, bus.q, bus.qb, ev[i]); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL sr_err_%0d got=%b exp=0", i, bus.err); end
    end
  endtask

  task automatic test_jk;
    logic [W-1:0] ev[3] = '{4'hF, 4'h0, 4'hF};
    step(0, 1, 2'b10, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b01, 4'hF, 4'hF, 0);
      total++; if (bus.q !== ev[i] || bus.qb !== ~ev[i]) begin bad++; $display("FAIL jk_%0d got q=%b qb=%b exp q=%b", i, bus.q, bus.qb, ev[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 2'b01, 4'hF, 4'hF, 0);
      total++; if (bus.q !== 4'hF) begin bad++; $display("FAIL jk_hold_%0d got=%b exp=1111", i, bus.q); end
    end
    total++; if (bus.err !== 1'b0 || bus.err_vec !== 4'h0) begin bad++; $display("FAIL jk_err got=%b/%b exp=0/0000", bus.err, bus.err_vec); end
  endtask

  task automatic test_forbidden;
    step(0, 1, 2'b10, 4'b0101, 4'h0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 2'b00, 4'b0011, 4'b0011, 0);
      total++; if (bus.q !== 4'b0101 || bus.err_vec !== 4'b0011) begin bad++; $display("FAIL forb_%0d got q=%b vec=%b exp q=0101 vec=0011", i, bus.q, bus.err_vec); end
      total++; if (bus.err !== 1'b1 || bus.err_cnt !== 2'(cnt_exp(i))) begin bad++; $display("FAIL forb_cnt_%0d got err=%b cnt=%0d exp err=1 cnt=%0d", i, bus.err, bus.err_cnt, cnt_exp(i)); end
    end
    step(0, 1, 2'b00, 4'b0011, 4'b0011, 1);
    total++; if (bus.err !== 1'b1 || bus.err_cnt !== 2'(cnt_exp(1))) begin bad++; $display("FAIL clr_set got err=%b cnt=%0d exp err=1 cnt=%0d", bus.err, bus.err_cnt, cnt_exp(1)); end
    step(0, 1, 2'b00, 4'b0000, 4'b0000, 1);
    total++; if (bus.err !== 1'b0 || bus.err_cnt !== 2'd0 || bus.err_vec !== 4'h0) begin bad++; $display("FAIL clr got err=%b cnt=%0d vec=%b exp 0/0/0000", bus.err, bus.err_cnt, bus.err_vec); end
  endtask

  task automatic test_toggle;
    step(0, 1, 2'b10, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b11, 4'b0001, 4'hF, 0);
      total++; if (bus.q !== {3'b000, 1'(i % 2 == 0)} || bus.err !== 1'b0) begin bad++; $display("FAIL tog_%0d got q=%b err=%b exp q[0]=%0d", i, bus.q, bus.err, (i % 2 == 0)); end
    end
    step(1, 1, 2'b11, 4'b0001, 4'h0, 0);
    total++; if (bus.q !== 4'h0 || bus.qb !== 4'hF) begin bad++; $display("FAIL tog_rst got q=%b qb=%b exp 0000/1111", bus.q, bus.qb); end
  endtask

  task automatic test_saturate;
    int ev[5] = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b00, 4'b1000, 4'b1000, 0);
      total++; if (bus.err_cnt !== 2'(cnt_exp(ev[i]))) begin bad++; $display("FAIL sat_%0d got=%0d exp=%0d", i, bus.err_cnt, cnt_exp(ev[i])); end
    end
    step(0, 0, 2'b00, 4'hF, 4'hF, 0);
    total++; if (bus.err !== 1'b1 || bus.err_vec !== 4'b1000) begin bad++; $display("FAIL idle_hold got err=%b vec=%b exp 1/1000", bus.err, bus.err_vec); end
    step(0, 0, 2'b00, 4'hF, 4'hF, 1);
    total++; if (bus.err !== 1'b0 || bus.err_cnt !== 2'd0) begin bad++; $display("FAIL idle_clr got err=%b cnt=%0d exp 0/0", bus.err, bus.err_cnt); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
      total++;
      if (bus.q !== mq || bus.qb !== ~mq || bus.err !== merr || bus.err_vec !== mvec || bus.err_cnt !== 2'(mcnt)) begin
        bad++;
        $display("FAIL rand_%0d got q=%b qb=%b err=%b vec=%b cnt=%0d exp q=%b err=%b vec=%b cnt=%0d", n, bus.q, bus.qb, bus.err, bus.err_vec, bus.err_cnt, mq, merr, mvec, mcnt);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = 2'b00; bus.a = '0; bus.b = '0; bus.clr_err = 1'b0;
    test_reset;
    test_sr;
    test_jk;
    test_forbidden;
    test_toggle;
    test_saturate;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
